// File: rtl/emergency_request_arbiter_if.sv
// Siren inputs and conditioned emergency requests between the detectors,
// emergency_request_arbiter and traffic_light_controller.
interface emergency_request_arbiter_if;
  // Emergency_* are level requests with no ready: the arbiter holds one side
  // high for a fixed time, and the controller must act on it while it is high.
  logic       siren_left;
  logic       siren_right;
  logic       Emergency_Left;
  logic       Emergency_Right;
  logic       emerg_busy;
  logic [1:0] emerg_pending;
  logic [1:0] dbg_state;

  modport slave (
    input  siren_left, siren_right,
    output Emergency_Left, Emergency_Right, emerg_busy, emerg_pending, dbg_state
  );

  modport master (
    output siren_left, siren_right,
    input  Emergency_Left, Emergency_Right, emerg_busy, emerg_pending, dbg_state
  );
endinterface

// File: rtl/emergency_request_arbiter.sv
// Synchronises, debounces and arbitrates siren detects into one-hot, fixed-length
// emergency requests followed by a cooldown. EMERG_PRIO_LEFT_EN selects left-priority ties.
module emergency_request_arbiter #(
  parameter int DEBOUNCE_CYC = 3,
  parameter int HOLD_CYC     = 10,
  parameter int COOLDOWN_CYC = 5
) (
  input  logic clk,
  input  logic reset,
  emergency_request_arbiter_if.slave bus
);

  localparam int MAX_A   = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_A > COOLDOWN_CYC) ? MAX_A : COOLDOWN_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DEB_FULL  = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYC - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT_L  = 2'd1;
  localparam logic [1:0] GRANT_R  = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  logic [1:0]    sync_l, sync_r;
  logic [CW-1:0] deb_l, deb_r;
  logic          req_l, req_r;
  logic          pend_l, pend_r;
  logic [1:0]    state, state_next;
  logic [CW-1:0] cnt;
  logic          last_grant_right;
  logic          grant_l, grant_r;
  logic          tie_left;
  logic          emerg_left_q, emerg_right_q, busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_l <= '0;
      sync_r <= '0;
      deb_l  <= '0;
      deb_r  <= '0;
    end else begin
      sync_l <= {sync_l[0], bus.siren_left};
      sync_r <= {sync_r[0], bus.siren_right};
      if (!sync_l[1])           deb_l <= '0;
      else if (deb_l != DEB_FULL) deb_l <= deb_l + CW'(1);
      if (!sync_r[1])           deb_r <= '0;
      else if (deb_r != DEB_FULL) deb_r <= deb_r + CW'(1);
    end
  end

  assign req_l = (deb_l == DEB_FULL);
  assign req_r = (deb_r == DEB_FULL);

`ifdef EMERG_PRIO_LEFT_EN
  assign tie_left = 1'b1;
`else
  // Round-robin: on a tie, serve whichever side was not granted last.
  assign tie_left = last_grant_right;
`endif

  always_comb begin
    state_next = state;
    grant_l    = 1'b0;
    grant_r    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_l && pend_r) begin
          grant_l = tie_left;
          grant_r = !tie_left;
        end else begin
          grant_l = pend_l;
          grant_r = pend_r;
        end
        if (grant_l)      state_next = GRANT_L;
        else if (grant_r) state_next = GRANT_R;
      end
      GRANT_L, GRANT_R: if (cnt == HOLD_LAST) state_next = COOLDOWN;
      COOLDOWN:         if (cnt == COOL_LAST) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      pend_l           <= 1'b0;
      pend_r           <= 1'b0;
      last_grant_right <= 1'b1;
      emerg_left_q     <= 1'b0;
      emerg_right_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)  cnt <= '0;
      else if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
      // Entering a grant clears that side; the other side may still latch a new request.
      pend_l <= grant_l ? 1'b0 : (pend_l | req_l);
      pend_r <= grant_r ? 1'b0 : (pend_r | req_r);
      if (grant_l)      last_grant_right <= 1'b0;
      else if (grant_r) last_grant_right <= 1'b1;
      emerg_left_q  <= (state_next == GRANT_L);
      emerg_right_q <= (state_next == GRANT_R);
      busy_q        <= (state_next != IDLE);
    end
  end

  assign bus.Emergency_Left  = emerg_left_q;
  assign bus.Emergency_Right = emerg_right_q;
  assign bus.emerg_busy      = busy_q;
  assign bus.emerg_pending   = {pend_r, pend_l};
  assign bus.dbg_state       = state;

endmodule
